calc2_req_initiator: RTL

- Requester side of the calc2 port protocol: one instance drives one calc2 request port (cmd/data/tag) and consumes the matching response port (resp/data/tag).
- Accepts operations on a local valid/ready interface and allocates one of 4 tags.
- Serialises each operation into the 2-cycle calc2 request, tracks outstanding tags with per-tag timeout, and returns completions in arrival order.
- Instantiated 4x in front of calc2_top in synthesizable traffic generators and in the bench.

---
 rtl/calc2_req_initiator.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/calc2_req_initiator.sv
// Requester side of the calc2 port: issues ops as 2-beat calc2 requests on 4 tags,
// times out unanswered tags and returns completions in arrival order.
module calc2_req_initiator #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  input  logic [1:0]  resp_tag_in,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [1:0]  cpl_tag,
  output logic [1:0]  cpl_status,
  output logic [31:0] cpl_data,
  output logic [3:0]  cpl_cmd,
  output logic [2:0]  outstanding,
  output logic        err_spurious
);

  localparam int NTAG = 4;
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {TagFree, TagPending, TagDone} tag_state_e;
  typedef enum logic {StIdle, StSendB} issue_state_e;

  tag_state_e       tag_state_q  [NTAG];
  tag_state_e       tag_state_d  [NTAG];
  logic [3:0]       tag_cmd_q    [NTAG];
  logic [1:0]       tag_status_q [NTAG];
  logic [31:0]      tag_data_q   [NTAG];
  logic [CNT_W-1:0] tag_cnt_q    [NTAG];

  issue_state_e issue_q;
  logic         run_q;
  logic [31:0]  b_q;

  logic [1:0] fifo_q [NTAG];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] fifo_cnt_q;

  logic       any_free, accept;
  logic [1:0] alloc_tag;
  logic       resp_hit, resp_spur;
  logic       to_valid;
  logic [1:0] to_tag;
  logic       push, pop;
  logic [1:0] push_tag, pop_tag;
  logic [2:0] outstanding_d;

  // Lowest-numbered free tag from the start-of-cycle state.
  always_comb begin
    any_free  = 1'b0;
    alloc_tag = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (tag_state_q[i] == TagFree) begin
        any_free  = 1'b1;
        alloc_tag = 2'(i);
      end
    end
  end

  assign op_ready = run_q && (issue_q == StIdle) && any_free;
  assign accept   = op_valid && op_ready;

  assign resp_hit  = (resp_in != 2'd0) && (tag_state_q[resp_tag_in] == TagPending);
  assign resp_spur = (resp_in != 2'd0) && (tag_state_q[resp_tag_in] != TagPending);

  // A tag expires on the edge where its count reaches TIMEOUT; a saturated count keeps
  // it expiring until a push slot is free.
  always_comb begin
    to_valid = 1'b0;
    to_tag   = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (tag_state_q[i] == TagPending && tag_cnt_q[i] >= TO_LAST) begin
        to_valid = 1'b1;
        to_tag   = 2'(i);
      end
    end
  end

  assign push     = resp_hit || to_valid;
  assign push_tag = resp_hit ? resp_tag_in : to_tag;
  assign pop      = cpl_valid && cpl_ready;
  assign pop_tag  = fifo_q[rd_ptr_q];

  // Accepted, pushed and popped tags are always distinct (FREE, PENDING, DONE).
  always_comb begin
    outstanding_d = '0;
    for (int i = 0; i < NTAG; i++) begin
      tag_state_d[i] = tag_state_q[i];
      if (accept && alloc_tag == 2'(i)) tag_state_d[i] = TagPending;
      if (push && push_tag == 2'(i))    tag_state_d[i] = TagDone;
      if (pop && pop_tag == 2'(i))      tag_state_d[i] = TagFree;
      if (tag_state_d[i] != TagFree)    outstanding_d = outstanding_d + 3'd1;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAG; i++) begin
        tag_state_q[i]  <= TagFree;
        tag_cmd_q[i]    <= '0;
        tag_status_q[i] <= '0;
        tag_data_q[i]   <= '0;
        tag_cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NTAG; i++) begin
        tag_state_q[i] <= tag_state_d[i];
        if (accept && alloc_tag == 2'(i)) begin
          tag_cmd_q[i] <= op_cmd;
          tag_cnt_q[i] <= '0;
        end else if (tag_state_q[i] == TagPending && tag_cnt_q[i] < TO_MAX) begin
          tag_cnt_q[i] <= tag_cnt_q[i] + CNT_W'(1);
        end
        if (push && push_tag == 2'(i)) begin
          tag_status_q[i] <= resp_hit ? resp_in : 2'd3;
          tag_data_q[i]   <= resp_hit ? resp_data_in : 32'd0;
        end
        if (pop && pop_tag == 2'(i)) begin
          tag_cmd_q[i]    <= '0;
          tag_status_q[i] <= '0;
          tag_data_q[i]   <= '0;
          tag_cnt_q[i]    <= '0;
        end
      end
    end
  end

  // Issue FSM: beat 1 carries cmd/op_a/tag, beat 2 carries op_b only.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      issue_q      <= StIdle;
      run_q        <= 1'b0;
      b_q          <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      req_tag_out  <= '0;
    end else begin
      run_q <= 1'b1;
      unique case (issue_q)
        StIdle: begin
          if (accept) begin
            req_cmd_out  <= op_cmd;
            req_data_out <= op_a;
            req_tag_out  <= alloc_tag;
            b_q          <= op_b;
            issue_q      <= StSendB;
          end else begin
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
          end
        end
        StSendB: begin
          req_cmd_out  <= '0;
          req_data_out <= b_q;
          req_tag_out  <= '0;
          issue_q      <= StIdle;
        end
        default: issue_q <= StIdle;
      endcase
    end
  end

  // Completion FIFO holds tags only; it cannot overflow since a tag frees on pop.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAG; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      outstanding  <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_tag;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      fifo_cnt_q   <= fifo_cnt_q + 3'(push) - 3'(pop);
      outstanding  <= outstanding_d;
      err_spurious <= resp_spur;
    end
  end

  assign cpl_valid  = (fifo_cnt_q != 3'd0);
  assign cpl_tag    = cpl_valid ? pop_tag : 2'd0;
  assign cpl_status = cpl_valid ? tag_status_q[pop_tag] : 2'd0;
  assign cpl_data   = cpl_valid ? tag_data_q[pop_tag] : 32'd0;
  assign cpl_cmd    = cpl_valid ? tag_cmd_q[pop_tag] : 4'd0;

endmodule
